alu_host_sequencer: RTL
=======================

Name: alu_host_sequencer

Overview:
- Initiator side of the ALU operand/result bus. Takes a request (op code plus two operands) over a valid/ready handshake.
- Drives the ALU's BEGIN / op_code / inbus sequence, watches outbus and END, then returns the assembled result over a second valid/ready handshake.
- Sits between the system/testbench command source and the ALU; it is the only driver of the ALU inputs.
- A watchdog aborts an operation if END never arrives.

Parameters:
- WIDTH, 8, ALU bus width; width of inbus, outbus, each operand and each result byte.
- TIMEOUT_CYCLES, 64, cycles allowed in WAIT before abort; must be at least 2.
- TMR_W, $clog2(TIMEOUT_CYCLES+1), watchdog counter width (derived, not overridden).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clock edge).
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  2  00 add, 01 sub, 10 mul, 11 div.
- req_x  in  WIDTH  first operand (dividend / multiplicand / augend).
- req_y  in  WIDTH  second operand (divisor / multiplier / addend).
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts the result.
- rsp_result  out  2*WIDTH  {hi, lo} result.
- rsp_error  out  1  1 = watchdog abort.
- busy  out  1  high in every state except IDLE.
- alu_begin  out  1  to ALU BEGIN.
- alu_op_code  out  2  to ALU op_code.
- alu_inbus  out  WIDTH  to ALU inbus.
- alu_outbus  in  WIDTH  from ALU outbus.
- alu_end  in  1  from ALU END.

Behaviour:
- States: IDLE, START, LOAD_X, LOAD_Y, WAIT, RESP. One-hot or binary encoding is an implementer's choice.
- Reset (reset==0): next state is IDLE. All outputs go to 0 except req_ready=1. Operand, op and capture registers clear and the watchdog clears. This applies from any state, including mid-WAIT; the ALU shares the system reset.
- IDLE: req_ready=1. When req_valid&req_ready, latch op/x/y and go to START. No other state asserts req_ready.
- START: alu_begin=1 for exactly one cycle; alu_op_code=latched op; go to LOAD_X.
- LOAD_X: alu_inbus=x; go to LOAD_Y.
- LOAD_Y: alu_inbus=y; go to WAIT; clear watchdog.
- alu_op_code holds the latched op from START through WAIT and is 0 otherwise. alu_inbus is 0 outside LOAD_X/LOAD_Y.
- WAIT capture: every cycle, prev_byte<=alu_outbus and the watchdog increments.
- WAIT with alu_end=1: result is captured and the state goes to RESP with rsp_error=0.
  - ops 10/11: result = {prev_byte, alu_outbus}. Mul is {A high, Q low}; div is {remainder, quotient}.
  - ops 00/01: result = {8'h00, alu_outbus}.
- WAIT timeout: watchdog reaches TIMEOUT_CYCLES with no END → RESP, result=0, rsp_error=1.
- END in the same cycle as expiry: END wins and rsp_error=0.
- RESP: rsp_valid=1, with rsp_result and rsp_error held stable until rsp_ready. On the rsp_valid&rsp_ready cycle go to IDLE; the next request is accepted one cycle later at the earliest.
- alu_end outside WAIT is ignored.
- Latency: request accepted at cycle 0 → BEGIN at cycle 1, x on inbus at cycle 2, y at cycle 3. END at cycle n≥4 → rsp_valid at n+1.

Decomposition:
- Package alu_bus_pkg:
  - OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11.
  - State encoding constants.
  - Function is_two_byte(op).
- Sub-module alu_watchdog_timer (clear, enable, expired output, TIMEOUT_CYCLES parameter).
- The FSM, operand latches and capture register stay in the top level.

Test Plan:
- ADD x=0x25, y=0x13; model drives outbus=0x38 with END at cycle 6 → alu_begin only at cycle 1 with op 00; inbus 0x25 at cycle 2, 0x13 at cycle 3; rsp_valid at cycle 7, rsp_result=0x0038, rsp_error=0.
- MUL 0x0C×0x0A; model outputs 0x00, then 0x78 with END → rsp_result=0x0078; alu_op_code=10 throughout WAIT.
- DIV 100/7; model outputs 0x02, then 0x0E with END → rsp_result=0x020E, rsp_error=0.
- Timeout: model never asserts END, TIMEOUT_CYCLES=64 → rsp_valid exactly 64 cycles after WAIT entry, rsp_result=0x0000, rsp_error=1. Variant with END in the expiry cycle → rsp_error=0.
- Backpressure: rsp_ready held 0 for 5 cycles with req_valid=1 and a new request → req_ready stays 0, rsp_result stable, no alu_begin. After acceptance, the new request gets BEGIN two cycles later.
- Reset mid-WAIT: reset=0 for one cycle → next cycle all ALU-side outputs 0, rsp_valid=0, busy=0, req_ready=1. A following SUB 0x10−0x01 (model outbus 0x0F) → rsp_result=0x000F.

Source files
------------

// File: rtl/alu_bus_pkg.sv
// Shared definitions for the ALU operand/result bus: op codes, sequencer
// state encoding and op classification.
package alu_bus_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_LOAD_X = 3'd2,
      S_LOAD_Y = 3'd3,
      S_WAIT   = 3'd4,
      S_RESP   = 3'd5
   } seq_state_t;

   // Mul and div return a high byte one cycle before the final low byte.
   function automatic logic is_two_byte(input logic [1:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_watchdog_timer.sv
// Counts enabled cycles since the last clear; expired_o flags the enabled
// cycle in which the count reaches TIMEOUT_CYCLES.
module alu_watchdog_timer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMR_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && (cnt_q != TMR_W'(TIMEOUT_CYCLES))) begin
         cnt_d = cnt_q + TMR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Flag the cycle whose increment lands on TIMEOUT_CYCLES, so the
   // sequencer leaves WAIT exactly TIMEOUT_CYCLES cycles after entering it.
   assign expired_o = enable_i && (cnt_q >= TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/alu_host_sequencer.sv
// Initiator of the ALU bus: accepts an op request, sequences BEGIN/op/x/y,
// collects the result bytes on END (or aborts on watchdog) and returns them.
module alu_host_sequencer
   import alu_bus_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [1:0]         req_op,
   input  logic [WIDTH-1:0]   req_x,
   input  logic [WIDTH-1:0]   req_y,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [2*WIDTH-1:0] rsp_result,
   output logic               rsp_error,
   output logic               busy,
   output logic               alu_begin,
   output logic [1:0]         alu_op_code,
   output logic [WIDTH-1:0]   alu_inbus,
   input  logic [WIDTH-1:0]   alu_outbus,
   input  logic               alu_end,
   output logic [2:0]         dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both high; rsp_result/rsp_error stay stable while rsp_valid waits.

   seq_state_t         state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   x_q, x_d;
   logic [WIDTH-1:0]   y_q, y_d;
   logic [WIDTH-1:0]   prev_q, prev_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               error_q, error_d;
   logic               wd_clear, wd_enable, wd_expired;

   alu_watchdog_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (wd_clear),
      .enable_i  (wd_enable),
      .expired_o (wd_expired)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      x_d       = x_q;
      y_d       = y_q;
      prev_d    = prev_q;
      result_d  = result_q;
      error_d   = error_q;
      wd_clear  = 1'b0;
      wd_enable = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op_d    = req_op;
               x_d     = req_x;
               y_d     = req_y;
               state_d = S_START;
            end
         end
         S_START:  state_d = S_LOAD_X;
         S_LOAD_X: state_d = S_LOAD_Y;
         S_LOAD_Y: begin
            wd_clear = 1'b1;
            prev_d   = '0;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            prev_d    = alu_outbus;
            wd_enable = 1'b1;
            // END takes priority over a watchdog expiry in the same cycle.
            if (alu_end) begin
               result_d = is_two_byte(op_q) ? {prev_q, alu_outbus}
                                            : {{WIDTH{1'b0}}, alu_outbus};
               error_d  = 1'b0;
               state_d  = S_RESP;
            end else if (wd_expired) begin
               result_d = '0;
               error_d  = 1'b1;
               state_d  = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         x_q      <= '0;
         y_q      <= '0;
         prev_q   <= '0;
         result_q <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         x_q      <= x_d;
         y_q      <= y_d;
         prev_q   <= prev_d;
         result_q <= result_d;
         error_q  <= error_d;
      end
   end

   assign req_ready   = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign alu_begin   = (state_q == S_START);
   assign alu_op_code = ((state_q == S_START) || (state_q == S_LOAD_X) ||
                         (state_q == S_LOAD_Y) || (state_q == S_WAIT)) ? op_q : 2'b00;
   assign alu_inbus   = (state_q == S_LOAD_X) ? x_q :
                        (state_q == S_LOAD_Y) ? y_q : '0;
   assign rsp_valid   = (state_q == S_RESP);
   assign rsp_result  = (state_q == S_RESP) ? result_q : '0;
   assign rsp_error   = (state_q == S_RESP) ? error_q : 1'b0;
   assign dbg_state   = state_q;

endmodule
